// File: rtl/lcd_frame_streamer_if.sv
// rtl/lcd_frame_streamer_if.sv - character stream link between frame streamer and LCD writer
//
// Signals:
//   ch_valid  streamer -> sink  character valid
//   ch_ready  sink -> streamer  character accepted when high with ch_valid
//   ch_data   streamer -> sink  ASCII character
//   ch_row    streamer -> sink  row of ch_data
//   ch_col    streamer -> sink  column of ch_data
// Modports: master (streamer side), slave (LCD writer side).

interface lcd_frame_streamer_if #(
    parameter int ROWS = 2,
    parameter int COLS = 16
);
    localparam int ROW_W = $clog2(ROWS) + 1;
    localparam int COL_W = $clog2(COLS) + 1;

    logic             ch_valid;
    logic             ch_ready;
    logic [7:0]       ch_data;
    logic [ROW_W-1:0] ch_row;
    logic [COL_W-1:0] ch_col;

    modport master (
        output ch_valid,
        output ch_data,
        output ch_row,
        output ch_col,
        input  ch_ready
    );

    modport slave (
        input  ch_valid,
        input  ch_data,
        input  ch_row,
        input  ch_col,
        output ch_ready
    );
endinterface

// File: rtl/lcd_frame_streamer.sv
// rtl/lcd_frame_streamer.sv - snapshots CPU debug taps and streams one LCD frame of ASCII characters
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   start        frame request pulse, honoured only while idle
//   mode         0 instr/PC, 1 register dump, 2 DMem dump, 3 banner
//   instr, pc    current instruction and PC
//   idx          base register/address index shown on row 0
//   words        ROWS data words, word r at [r*WORD_W +: WORD_W]
//   ch           character stream (master modport of lcd_frame_streamer_if)
//   busy         high whenever a frame is in progress
//   frame_done   one-cycle pulse after the last character is accepted
// Optional feature: define LCD_AUTO_REFRESH_EN to start a frame automatically
// after REFRESH_CYC idle cycles.

module lcd_frame_streamer #(
    parameter int COLS        = 16,
    parameter int ROWS        = 2,
    parameter int WORD_W      = 32,
    parameter int REFRESH_CYC = 1000000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [1:0]               mode,
    input  logic [15:0]              instr,
    input  logic [15:0]              pc,
    input  logic [3:0]               idx,
    input  logic [ROWS*WORD_W-1:0]   words,
    lcd_frame_streamer_if.master     ch,
    output logic                     busy,
    output logic                     frame_done
);
    localparam int ROW_W = $clog2(ROWS) + 1;
    localparam int COL_W = $clog2(COLS) + 1;
    localparam int ND    = WORD_W / 4;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LATCH  = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [63:0] TXT_DEFAULT3 = "Default3";
    localparam logic [23:0] TXT_PC       = "PC=";
    localparam logic [23:0] TXT_REG      = "Reg";
    localparam logic [31:0] TXT_DMEM     = "DMem";

    logic [1:0]              state;
    logic [ROW_W-1:0]        row_q;
    logic [COL_W-1:0]        col_q;
    logic [1:0]              s_mode;
    logic [15:0]             s_instr;
    logic [15:0]             s_pc;
    logic [3:0]              s_idx;
    logic [ROWS*WORD_W-1:0]  s_words;
    logic                    go;

    function automatic logic [7:0] hex_ch(input logic [3:0] h);
        return (h < 4'd10) ? (8'h30 + {4'h0, h}) : (8'h37 + {4'h0, h});
    endfunction

`ifdef LCD_AUTO_REFRESH_EN
    logic [31:0] refresh_cnt;

    assign go = start || (refresh_cnt == 32'(REFRESH_CYC - 1));

    // Counts idle cycles only; any frame start or non-idle cycle restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
        end else if (state != IDLE || go) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + 32'd1;
        end
    end
`else
    assign go = start;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            s_mode  <= '0;
            s_instr <= '0;
            s_pc    <= '0;
            s_idx   <= '0;
            s_words <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) state <= LATCH;
                end
                LATCH: begin
                    s_mode  <= mode;
                    s_instr <= instr;
                    s_pc    <= pc;
                    s_idx   <= idx;
                    s_words <= words;
                    row_q   <= '0;
                    col_q   <= '0;
                    state   <= STREAM;
                end
                STREAM: begin
                    if (ch.ch_ready) begin
                        if (col_q == COL_W'(COLS - 1)) begin
                            col_q <= '0;
                            if (row_q == ROW_W'(ROWS - 1)) begin
                                row_q <= '0;
                                state <= DONE;
                            end else begin
                                row_q <= row_q + 1'b1;
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign frame_done  = (state == DONE);
    assign ch.ch_valid = (state == STREAM);
    assign ch.ch_row   = row_q;
    assign ch.ch_col   = col_q;

    // Character generator: purely a function of the position counters and the
    // snapshot, so the output cannot move while a character waits for ready.
    int                c;
    int                r;
    int                ml;
    logic [31:0]       mn;
    logic [3:0]        ix;
    logic [WORD_W-1:0] w;
    logic [WORD_W-1:0] w_sh;
    logic [15:0]       pc_sh;
    logic [7:0]        ch_char;

    always_comb begin
        c       = int'(col_q);
        r       = int'(row_q);
        ix      = s_idx + 4'(r);
        w       = s_words[row_q*WORD_W +: WORD_W];
        w_sh    = '0;
        pc_sh   = '0;
        mn      = "    ";
        ml      = 0;
        ch_char = 8'h20;

        case (s_instr[15:12])
            4'h0: begin mn = "And "; ml = 3; end
            4'h1: begin mn = "or  "; ml = 2; end
            4'h2: begin mn = "Add "; ml = 3; end
            4'h3: begin mn = "Addi"; ml = 4; end
            4'h6: begin mn = "Sub "; ml = 3; end
            4'h7: begin mn = "SLT "; ml = 3; end
            4'h8: begin mn = "LW  "; ml = 2; end
            4'hA: begin mn = "SW  "; ml = 2; end
            4'hE: begin mn = "BNE "; ml = 3; end
            4'hF: begin mn = "Jump"; ml = 4; end
            default: begin mn = "    "; ml = 0; end
        endcase

        case (s_mode)
            2'd0: begin
                if (r == 0) begin
                    if (ml == 0) begin
                        // Unknown opcode: "Default" followed by a NUL byte.
                        if (c < 7)       ch_char = TXT_DEFAULT3[63-8*c -: 8];
                        else if (c == 7) ch_char = 8'h00;
                    end else if (c < ml) begin
                        ch_char = mn[31-8*c -: 8];
                    end else begin
                        case (c - ml)
                            0, 3, 6: ch_char = 8'h20;
                            1, 4, 7: ch_char = 8'h24;
                            2:       ch_char = hex_ch(s_instr[11:8]);
                            5:       ch_char = hex_ch(s_instr[7:4]);
                            8:       ch_char = hex_ch(s_instr[3:0]);
                            default: ch_char = 8'h20;
                        endcase
                    end
                end else if (r == 1) begin
                    if (c < 3) begin
                        ch_char = TXT_PC[23-8*c -: 8];
                    end else if (c < 7) begin
                        pc_sh   = s_pc >> (4 * (6 - c));
                        ch_char = hex_ch(pc_sh[3:0]);
                    end
                end
            end
            2'd1: begin
                if (c < 3) begin
                    ch_char = TXT_REG[23-8*c -: 8];
                end else if (c == 3) begin
                    ch_char = hex_ch(ix);
                end else if (c == 4) begin
                    ch_char = 8'h3A;
                end else if (c < 5 + ND) begin
                    w_sh    = w >> (4 * (ND - 1 - (c - 5)));
                    ch_char = hex_ch(w_sh[3:0]);
                end
            end
            2'd2: begin
                if (c < 4) begin
                    ch_char = TXT_DMEM[31-8*c -: 8];
                end else if (c == 4) begin
                    ch_char = hex_ch(ix);
                end else if (c == 5) begin
                    ch_char = 8'h3A;
                end else if (c < 6 + ND) begin
                    w_sh    = w >> (4 * (ND - 1 - (c - 6)));
                    ch_char = hex_ch(w_sh[3:0]);
                end
            end
            default: begin
                if (r == 0 && c < 8) ch_char = TXT_DEFAULT3[63-8*c -: 8];
            end
        endcase
    end

    assign ch.ch_data = ch_char;
endmodule
